// File: rtl/sobel_mem_sched.sv
// Memory-access scheduler for the Sobel accelerator: sequences the 3-row column reads,
// the result write-back and the zero border rows on a single-port word memory.
module sobel_mem_sched #(
    parameter int WPR      = 88,
    parameter int ROWS     = 288,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 25344
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        finish,
    output logic [15:0] addr,
    output logic        en,
    output logic        we,
    output logic [31:0] dataW,
    output logic        dp_rd_valid,
    output logic [1:0]  dp_rd_row,
    output logic        dp_col_first,
    output logic        dp_wr_take,
    input  logic [31:0] dp_wr_data
);

    // state | meaning
    // IDLE  | waiting for start
    // BTOP  | zero top destination row, col 0..WPR-1
    // RD0-2 | read rows r-1, r, r+1 at column c
    // CALC  | no access; datapath consumes the column
    // WR    | write result for column c-1
    // FLUSH | write result for last column of row r
    // BBOT  | zero bottom destination row
    // DONE  | finish high until start drops
    typedef enum logic [3:0] {
        S_IDLE, S_BTOP, S_RD0, S_RD1, S_RD2, S_CALC, S_WR, S_FLUSH, S_BBOT, S_DONE
    } state_t;

    localparam logic [15:0] A_SRC   = 16'(SRC_BASE);
    localparam logic [15:0] A_DST   = 16'(DST_BASE);
    localparam logic [15:0] A_WPR   = 16'(WPR);
    localparam logic [15:0] A_WPR2  = 16'(2 * WPR);
    localparam logic [15:0] A_LASTC = 16'(WPR - 1);
    localparam logic [15:0] A_BOT   = 16'(DST_BASE + (ROWS - 1) * WPR);
    localparam logic [6:0]  C_LAST  = 7'(WPR - 1);
    localparam logic [8:0]  R_LAST  = 9'(ROWS - 2);

    state_t      r_state;
    logic [8:0]  r_r;
    logic [6:0]  r_c;
    logic [6:0]  r_col;
    logic [15:0] r_src_base;
    logic [15:0] r_dst_base;
    logic        r_en, r_we, r_take, r_finish;
    logic [15:0] r_addr;
    logic [31:0] r_dataW;
    logic [1:0]  r_row_iss;
    logic        r_cf_iss;
    logic        r_rd_valid, r_col_first;
    logic [1:0]  r_rd_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_r         <= '0;
            r_c         <= '0;
            r_col       <= '0;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_take      <= 1'b0;
            r_finish    <= 1'b0;
            r_addr      <= '0;
            r_dataW     <= '0;
            r_row_iss   <= '0;
            r_cf_iss    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_col_first <= 1'b0;
            r_rd_row    <= '0;
        end else begin
            r_en      <= 1'b0;
            r_we      <= 1'b0;
            r_take    <= 1'b0;
            r_finish  <= 1'b0;
            r_addr    <= '0;
            r_dataW   <= '0;
            r_row_iss <= '0;
            r_cf_iss  <= 1'b0;
            // Delivery-side tags follow the issued read by one cycle (synchronous memory).
            r_rd_valid  <= r_en & ~r_we;
            r_rd_row    <= r_row_iss;
            r_col_first <= r_en & ~r_we & r_cf_iss;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col   <= '0;
                        r_state <= S_BTOP;
                    end
                end
                S_BTOP: begin
                    r_en   <= 1'b1;
                    r_we   <= 1'b1;
                    r_addr <= A_DST + {9'd0, r_col};
                    if (r_col == C_LAST) begin
                        r_r        <= 9'd1;
                        r_c        <= '0;
                        r_src_base <= A_SRC;
                        r_dst_base <= A_DST + A_WPR;
                        r_state    <= S_RD0;
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                end
                S_RD0: begin
                    r_en      <= 1'b1;
                    r_addr    <= r_src_base + {9'd0, r_c};
                    r_row_iss <= 2'd0;
                    r_cf_iss  <= (r_c == 7'd0);
                    r_state   <= S_RD1;
                end
                S_RD1: begin
                    r_en      <= 1'b1;
                    r_addr    <= r_src_base + A_WPR + {9'd0, r_c};
                    r_row_iss <= 2'd1;
                    r_cf_iss  <= (r_c == 7'd0);
                    r_state   <= S_RD2;
                end
                S_RD2: begin
                    r_en      <= 1'b1;
                    r_addr    <= r_src_base + A_WPR2 + {9'd0, r_c};
                    r_row_iss <= 2'd2;
                    r_cf_iss  <= (r_c == 7'd0);
                    r_state   <= S_CALC;
                end
                S_CALC: begin
                    // Column 0 only primes the window; there is no result to write yet.
                    if (r_c == 7'd0) begin
                        r_c     <= 7'd1;
                        r_state <= S_RD0;
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_en    <= 1'b1;
                    r_we    <= 1'b1;
                    r_take  <= 1'b1;
                    r_addr  <= r_dst_base + {9'd0, r_c} - 16'd1;
                    r_dataW <= dp_wr_data;
                    if (r_c == C_LAST) begin
                        r_state <= S_FLUSH;
                    end else begin
                        r_c     <= r_c + 7'd1;
                        r_state <= S_RD0;
                    end
                end
                S_FLUSH: begin
                    r_en    <= 1'b1;
                    r_we    <= 1'b1;
                    r_take  <= 1'b1;
                    r_addr  <= r_dst_base + A_LASTC;
                    r_dataW <= dp_wr_data;
                    if (r_r == R_LAST) begin
                        r_col   <= '0;
                        r_state <= S_BBOT;
                    end else begin
                        r_r        <= r_r + 9'd1;
                        r_c        <= '0;
                        r_src_base <= r_src_base + A_WPR;
                        r_dst_base <= r_dst_base + A_WPR;
                        r_state    <= S_RD0;
                    end
                end
                S_BBOT: begin
                    r_en   <= 1'b1;
                    r_we   <= 1'b1;
                    r_addr <= A_BOT + {9'd0, r_col};
                    if (r_col == C_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                end
                S_DONE: begin
                    r_finish <= 1'b1;
                    if (!start) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign finish       = r_finish;
    assign addr         = r_addr;
    assign en           = r_en;
    assign we           = r_we;
    assign dataW        = r_dataW;
    assign dp_rd_valid  = r_rd_valid;
    assign dp_rd_row    = r_rd_row;
    assign dp_col_first = r_col_first;
    assign dp_wr_take   = r_take;

endmodule

// File: tb/tb_sobel_mem_sched.sv
// Scoreboard bench for sobel_mem_sched: the expected per-cycle memory/datapath view of a
// frame is generated from row/column loops and compared cycle by cycle.
module tb_sobel_mem_sched;

    // Full-width rows with a short image keep the run small; frame length scales with ROWS.
    localparam int WPR      = 88;
    localparam int ROWS     = 8;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 25344;
    localparam int FRAME_CYC = 2 * WPR + (ROWS - 2) * (4 + (WPR - 1) * 5 + 1);

    typedef logic [55:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        finish;
    logic [15:0] addr;
    logic        en;
    logic        we;
    logic [31:0] dataW;
    logic        dp_rd_valid;
    logic [1:0]  dp_rd_row;
    logic        dp_col_first;
    logic        dp_wr_take;
    logic [31:0] dp_wr_data;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t q[$];
    bit   m_rd;
    logic [1:0] m_row;
    bit   m_cf;
    int   first_fin;

    always #5 clk = ~clk;

    sobel_mem_sched #(
        .WPR(WPR), .ROWS(ROWS), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .addr(addr), .en(en), .we(we), .dataW(dataW),
        .dp_rd_valid(dp_rd_valid), .dp_rd_row(dp_rd_row), .dp_col_first(dp_col_first),
        .dp_wr_take(dp_wr_take), .dp_wr_data(dp_wr_data)
    );

    function automatic vec_t obs();
        return {en, we, addr, dataW, dp_wr_take, dp_rd_valid, dp_rd_row, dp_col_first, finish};
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        n_checks++;
        assert (o === e) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected cycle: the delivery tags come from whatever the previous cycle issued.
    task automatic push(input bit e, input bit w, input int a, input logic [31:0] d,
                        input bit tk, input int row, input bit cf, input bit fin);
        q.push_back({e, w, 16'(a), d, tk, m_rd, m_row, m_cf, fin});
        m_rd  = e & ~w;
        m_row = (e & ~w) ? 2'(row) : 2'd0;
        m_cf  = e & ~w & cf;
    endtask

    task automatic model_reset();
        q.delete();
        m_rd  = 1'b0;
        m_row = 2'd0;
        m_cf  = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] d);
        for (int col = 0; col < WPR; col++)
            push(1, 1, DST_BASE + col, 32'd0, 0, 0, 0, 0);
        for (int r = 1; r <= ROWS - 2; r++) begin
            for (int c = 0; c < WPR; c++) begin
                for (int k = 0; k < 3; k++)
                    push(1, 0, SRC_BASE + (r - 1 + k) * WPR + c, 32'd0, 0, k, c == 0, 0);
                push(0, 0, 0, 32'd0, 0, 0, 0, 0);
                if (c > 0) push(1, 1, DST_BASE + r * WPR + c - 1, d, 1, 0, 0, 0);
            end
            push(1, 1, DST_BASE + r * WPR + WPR - 1, d, 1, 0, 0, 0);
        end
        for (int col = 0; col < WPR; col++)
            push(1, 1, DST_BASE + (ROWS - 1) * WPR + col, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic run_n(input int n, input string tag, output int fin_at);
        vec_t e;
        fin_at = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1 && fin_at < 0) fin_at = i;
            if (q.size() == 0) begin
                check($sformatf("%s_qempty_%0d", tag, i), obs(), 56'hFFFF_FFFF_FFFF_FF);
            end else begin
                e = q.pop_front();
                check($sformatf("%s_cyc%0d", tag, i), obs(), e);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        dp_wr_data = 32'h5A5A_0000;
        model_reset();
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("in_reset", obs(), '0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 check($sformatf("idle_%0d", i), obs(), '0);
        end

        // Frame 1, start held high throughout and afterwards: no restart from DONE.
        dp_wr_data = 32'hA5A5_A5A5;
        push_frame(32'hA5A5_A5A5);
        for (int i = 0; i < 5; i++) push(0, 0, 0, 32'd0, 0, 0, 0, 1);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 check("f1_start_edge", obs(), '0);
        run_n(FRAME_CYC + 5, "f1", first_fin);
        check("f1_finish_cycle", 56'(first_fin), 56'(FRAME_CYC + 1));

        push(0, 0, 0, 32'd0, 0, 0, 0, 1);
        push(0, 0, 0, 32'd0, 0, 0, 0, 0);
        @(negedge clk) start = 1'b0;
        run_n(2, "f1_release", first_fin);

        // Frame 2 is cut by reset in the middle of row 3.
        model_reset();
        dp_wr_data = 32'h3C3C_0F0F;
        push_frame(32'h3C3C_0F0F);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 check("f2_start_edge", obs(), '0);
        run_n(2 * WPR / 2 + 2 * 440 + 50, "f2", first_fin);
        #2 reset = 1'b1;
        #1 check("mid_reset", obs(), '0);
        start = 1'b0;
        model_reset();
        @(negedge clk) reset = 1'b0;

        // Frame 3 restarts cleanly from the top border.
        dp_wr_data = 32'h1234_5678;
        push_frame(32'h1234_5678);
        push(0, 0, 0, 32'd0, 0, 0, 0, 1);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 check("f3_start_edge", obs(), '0);
        run_n(FRAME_CYC + 1, "f3", first_fin);
        check("f3_finish_cycle", 56'(first_fin), 56'(FRAME_CYC + 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
